// File: rtl/dcsk_deserializer_pkg.sv
// Shared definitions for the DCSK chip serializer/deserializer pair.
package dcsk_pkg;

  localparam int DEFAULT_CHIP_WIDTH    = 8;
  localparam int DEFAULT_SPREAD_FACTOR = 2;

  // A frame is a reference half followed by a data half of equal length.
  localparam int FRAME_HALVES = 2;

  typedef logic signed [DEFAULT_CHIP_WIDTH-1:0] chip_t;

  // Accumulator width: a full-precision chip product plus enough headroom
  // for SPREAD_FACTOR products, so the correlation sum can never overflow.
  function automatic int acc_width(input int spread_factor, input int chip_width);
    return 2 * chip_width + $clog2(spread_factor) + 1;
  endfunction

endpackage

// File: rtl/dcsk_deserializer_if.sv
// Chip stream in, demodulated bit and correlation out.
interface dcsk_deserializer_if
  import dcsk_pkg::*;
#(
  parameter int SPREAD_FACTOR = DEFAULT_SPREAD_FACTOR,
  parameter int CHIP_WIDTH    = DEFAULT_CHIP_WIDTH
);

  localparam int IDX_W = $clog2(FRAME_HALVES * SPREAD_FACTOR);
  localparam int ACC_W = acc_width(SPREAD_FACTOR, CHIP_WIDTH);

  logic signed [CHIP_WIDTH-1:0] chip_in;
  logic                         chip_valid;
  logic                         frame_sync;
  logic [IDX_W-1:0]             chip_index;
  logic                         bit_out;
  logic                         bit_valid;
  logic signed [ACC_W-1:0]      corr_out;

  // The front end drives chips; the deserializer answers with bits.
  modport master (
    output chip_in, chip_valid, frame_sync,
    input  chip_index, bit_out, bit_valid, corr_out
  );

  modport slave (
    input  chip_in, chip_valid, frame_sync,
    output chip_index, bit_out, bit_valid, corr_out
  );

endinterface

// File: rtl/dcsk_deserializer_counter.sv
// Chip position within the frame, with explicit wrap and sync restart.
module deserialization_counter
  import dcsk_pkg::*;
#(
  parameter  int SPREAD_FACTOR = DEFAULT_SPREAD_FACTOR,
  localparam int IDX_W         = $clog2(FRAME_HALVES * SPREAD_FACTOR)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             sync_clear,
  output logic [IDX_W-1:0] index,
  output logic             is_ref_phase,
  output logic             is_last_chip
);

  localparam logic [IDX_W-1:0] HALF = IDX_W'(SPREAD_FACTOR);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_HALVES * SPREAD_FACTOR - 1);

  logic [IDX_W-1:0] index_q;
  logic [IDX_W-1:0] index_d;

  // Next index: a sync with a chip makes that chip index 0 so the next one
  // is 1; the wrap compares against LAST so non-power-of-two frames work.
  always_comb begin
    index_d = index_q;
    if (sync_clear) begin
      index_d = enable ? IDX_W'(1) : '0;
    end else if (enable) begin
      index_d = (index_q == LAST) ? '0 : index_q + 1'b1;
    end
  end

  // Index register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      index_q <= '0;
    end else begin
      index_q <= index_d;
    end
  end

  assign index        = index_q;
  assign is_ref_phase = (index_q < HALF);
  assign is_last_chip = (index_q == LAST);

endmodule

// File: rtl/dcsk_deserializer.sv
// DCSK receiver: buffers reference chips, correlates data chips against
// them and emits one registered bit decision per frame.
module dcsk_deserializer
  import dcsk_pkg::*;
#(
  parameter int SPREAD_FACTOR = DEFAULT_SPREAD_FACTOR,
  parameter int CHIP_WIDTH    = DEFAULT_CHIP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  dcsk_deserializer_if.slave   bus
);

  localparam int IDX_W  = $clog2(FRAME_HALVES * SPREAD_FACTOR);
  localparam int REF_W  = (SPREAD_FACTOR > 1) ? $clog2(SPREAD_FACTOR) : 1;
  localparam int ACC_W  = acc_width(SPREAD_FACTOR, CHIP_WIDTH);
  localparam int PROD_W = 2 * CHIP_WIDTH;
  localparam logic [IDX_W-1:0] HALF = IDX_W'(SPREAD_FACTOR);

  logic [IDX_W-1:0] chip_index;
  logic             is_ref_phase;
  logic             is_last_chip;
  logic             is_first_chip;

  logic [REF_W-1:0] ref_slot;
  logic [REF_W-1:0] data_slot;

  logic [CHIP_WIDTH-1:0] ref_buf_q [SPREAD_FACTOR];
  logic [CHIP_WIDTH-1:0] ref_buf_d [SPREAD_FACTOR];
  logic [CHIP_WIDTH-1:0] ref_rd;

  logic [PROD_W-1:0] product;
  logic [ACC_W-1:0]  product_ext;
  logic [ACC_W-1:0]  acc_sum;

  logic [ACC_W-1:0] acc_q,       acc_d;
  logic [ACC_W-1:0] corr_out_q,  corr_out_d;
  logic             bit_out_q,   bit_out_d;
  logic             bit_valid_q, bit_valid_d;

  deserialization_counter #(
    .SPREAD_FACTOR (SPREAD_FACTOR)
  ) u_counter (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (bus.chip_valid),
    .sync_clear   (bus.frame_sync),
    .index        (chip_index),
    .is_ref_phase (is_ref_phase),
    .is_last_chip (is_last_chip)
  );

  assign is_first_chip = (chip_index == '0);
  assign ref_slot      = REF_W'(chip_index);
  assign data_slot     = REF_W'(chip_index - HALF);
  assign ref_rd        = ref_buf_q[data_slot];

  // Both operands are sign-extended to the product width first, so the
  // unsigned multiply yields the exact two's-complement product.
  assign product     = {{CHIP_WIDTH{bus.chip_in[CHIP_WIDTH-1]}}, bus.chip_in}
                     * {{CHIP_WIDTH{ref_rd[CHIP_WIDTH-1]}}, ref_rd};
  assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
  assign acc_sum     = acc_q + product_ext;

  // Buffer, accumulate and decide; frame_sync overrides everything so an
  // aborted frame, even on its last chip, never produces a bit.
  always_comb begin
    for (int i = 0; i < SPREAD_FACTOR; i++) begin
      ref_buf_d[i] = ref_buf_q[i];
    end
    acc_d       = acc_q;
    corr_out_d  = corr_out_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    if (bus.frame_sync) begin
      acc_d = '0;
      if (bus.chip_valid) begin
        ref_buf_d[0] = bus.chip_in;
      end
    end else if (bus.chip_valid) begin
      if (is_ref_phase) begin
        ref_buf_d[ref_slot] = bus.chip_in;
        if (is_first_chip) begin
          acc_d = '0;
        end
      end else begin
        acc_d = acc_sum;
        if (is_last_chip) begin
          corr_out_d  = acc_sum;
          bit_out_d   = ~acc_sum[ACC_W-1] & (acc_sum != '0);
          bit_valid_d = 1'b1;
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SPREAD_FACTOR; i++) begin
        ref_buf_q[i] <= '0;
      end
      acc_q       <= '0;
      corr_out_q  <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < SPREAD_FACTOR; i++) begin
        ref_buf_q[i] <= ref_buf_d[i];
      end
      acc_q       <= acc_d;
      corr_out_q  <= corr_out_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign bus.chip_index = chip_index;
  assign bus.bit_out    = bit_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.corr_out   = corr_out_q;

endmodule

// File: tb/tb_dcsk_deserializer.sv
// Self-checking bench for dcsk_deserializer at SF=2 and SF=3.
module tb_dcsk_deserializer;
  import dcsk_pkg::*;

  typedef struct packed {
    logic signed [7:0] c0;
    logic signed [7:0] c1;
    logic signed [7:0] c2;
    logic signed [7:0] c3;
    int                exp_corr;
    logic              exp_bit;
  } vec_t;

  typedef struct packed {
    int   corr;
    logic b;
  } exp_t;

  logic clk;
  logic rstn;

  int n_vectors;
  int n_miscompares;
  int pulses3;

  exp_t q2[$];
  exp_t q3[$];
  vec_t vecs[7];

  dcsk_deserializer_if #(.SPREAD_FACTOR(2), .CHIP_WIDTH(8)) bus2 ();
  dcsk_deserializer_if #(.SPREAD_FACTOR(3), .CHIP_WIDTH(8)) bus3 ();

  dcsk_deserializer #(.SPREAD_FACTOR(2), .CHIP_WIDTH(8)) u_dut2 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus2.slave)
  );

  dcsk_deserializer #(.SPREAD_FACTOR(3), .CHIP_WIDTH(8)) u_dut3 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic applyStimulus(input logic signed [7:0] chip, input logic valid, input logic sync);
    @(negedge clk);
    bus2.chip_in    = chip;
    bus2.chip_valid = valid;
    bus2.frame_sync = sync;
  endtask

  task automatic push2(input int corr, input logic b);
    exp_t e;
    e.corr = corr;
    e.b    = b;
    q2.push_back(e);
  endtask

  task automatic send_frame(input vec_t v, input bit gap);
    logic signed [7:0] ch[4];
    ch[0] = v.c0;
    ch[1] = v.c1;
    ch[2] = v.c2;
    ch[3] = v.c3;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) push2(v.exp_corr, v.exp_bit);
      applyStimulus(ch[k], 1'b1, 1'b0);
      if (gap) applyStimulus(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 8 && (q2.size() != 0 || q3.size() != 0); k++) @(negedge clk);
    @(negedge clk);
    checkOutput(name, q2.size() + q3.size(), 0);
  endtask

  // Scoreboard for SF=2: every bit_valid must match a queued expectation.
  always @(negedge clk) begin
    if (rstn && bus2.bit_valid) begin
      if (q2.size() == 0) begin
        n_vectors++;
        n_miscompares++;
        $display("[TB] FAIL unexpected_bit_valid_sf2: got pulse, expected none");
      end else begin
        exp_t e;
        e = q2.pop_front();
        checkOutput("corr_out_sf2", int'(bus2.corr_out), e.corr);
        checkOutput("bit_out_sf2", int'(bus2.bit_out), int'(e.b));
      end
    end
  end

  // Scoreboard for SF=3.
  always @(negedge clk) begin
    if (rstn && bus3.bit_valid) begin
      pulses3++;
      if (q3.size() == 0) begin
        n_vectors++;
        n_miscompares++;
        $display("[TB] FAIL unexpected_bit_valid_sf3: got pulse, expected none");
      end else begin
        exp_t e;
        e = q3.pop_front();
        checkOutput("corr_out_sf3", int'(bus3.corr_out), e.corr);
        checkOutput("bit_out_sf3", int'(bus3.bit_out), int'(e.b));
      end
    end
  end

  initial begin
    logic signed [7:0] s3[12];
    vec_t v;

    n_vectors     = 0;
    n_miscompares = 0;
    pulses3       = 0;

    vecs[0] = '{ 8'sd10,  -8'sd20,   8'sd10,  -8'sd20,    500, 1'b1};
    vecs[1] = '{ 8'sd10,  -8'sd20,  -8'sd10,   8'sd20,   -500, 1'b0};
    vecs[2] = '{ 8'sd0,    8'sd0,    8'sd0,    8'sd0,       0, 1'b0};
    vecs[3] = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128, 32768, 1'b1};
    vecs[4] = '{ 8'sd127, -8'sd128,  8'sd127, -8'sd128, 32513, 1'b1};
    vecs[5] = '{-8'sd128,  8'sd127,  8'sd127, -8'sd128, -32512, 1'b0};
    vecs[6] = '{ 8'sd3,    8'sd5,   -8'sd2,    8'sd1,      -1, 1'b0};

    rstn            = 1'b0;
    bus2.chip_in    = '0;
    bus2.chip_valid = 1'b0;
    bus2.frame_sync = 1'b0;
    bus3.chip_in    = '0;
    bus3.chip_valid = 1'b0;
    bus3.frame_sync = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_chip_index", int'(bus2.chip_index), 0);
    checkOutput("reset_bit_out", int'(bus2.bit_out), 0);
    checkOutput("reset_bit_valid", int'(bus2.bit_valid), 0);
    checkOutput("reset_corr_out", int'(bus2.corr_out), 0);
    rstn = 1'b1;

    // Table of frames sent back to back.
    for (int i = 0; i < 7; i++) send_frame(vecs[i], 1'b0);
    applyStimulus(8'sd0, 1'b0, 1'b0);
    wait_drain("drain_table");

    // Extremes with chip_valid toggling every other cycle.
    send_frame(vecs[3], 1'b1);
    wait_drain("drain_gapped");

    // Sync with a chip on the third chip of a frame.
    applyStimulus(8'sd5, 1'b1, 1'b0);
    applyStimulus(8'sd7, 1'b1, 1'b0);
    applyStimulus(8'sd10, 1'b1, 1'b1);
    applyStimulus(8'sd0, 1'b0, 1'b0);
    checkOutput("chip_index_after_sync", int'(bus2.chip_index), 1);
    applyStimulus(-8'sd20, 1'b1, 1'b0);
    applyStimulus(8'sd10, 1'b1, 1'b0);
    push2(500, 1'b1);
    applyStimulus(-8'sd20, 1'b1, 1'b0);
    applyStimulus(8'sd0, 1'b0, 1'b0);
    wait_drain("drain_sync_mid");

    // Sync on the last chip of a frame: sync wins, no bit.
    applyStimulus(8'sd1, 1'b1, 1'b0);
    applyStimulus(8'sd2, 1'b1, 1'b0);
    applyStimulus(8'sd3, 1'b1, 1'b0);
    applyStimulus(8'sd4, 1'b1, 1'b1);
    applyStimulus(8'sd5, 1'b1, 1'b0);
    applyStimulus(8'sd6, 1'b1, 1'b0);
    push2(59, 1'b1);
    applyStimulus(8'sd7, 1'b1, 1'b0);
    applyStimulus(8'sd0, 1'b0, 1'b0);
    wait_drain("drain_sync_last");

    // Sync without a chip restarts at index 0.
    applyStimulus(8'sd1, 1'b1, 1'b0);
    applyStimulus(8'sd2, 1'b1, 1'b0);
    applyStimulus(8'sd0, 1'b0, 1'b1);
    applyStimulus(8'sd0, 1'b0, 1'b0);
    checkOutput("chip_index_sync_novalid", int'(bus2.chip_index), 0);
    send_frame(vecs[1], 1'b0);
    applyStimulus(8'sd0, 1'b0, 1'b0);
    wait_drain("drain_sync_novalid");

    // Asynchronous reset mid data phase, after a positive decision is held.
    send_frame(vecs[0], 1'b0);
    applyStimulus(8'sd0, 1'b0, 1'b0);
    wait_drain("drain_pre_reset");
    applyStimulus(8'sd10, 1'b1, 1'b0);
    applyStimulus(-8'sd20, 1'b1, 1'b0);
    applyStimulus(8'sd10, 1'b1, 1'b0);
    @(negedge clk);
    #1 rstn = 1'b0;
    bus2.chip_valid = 1'b0;
    #1;
    checkOutput("async_reset_chip_index", int'(bus2.chip_index), 0);
    checkOutput("async_reset_bit_out", int'(bus2.bit_out), 0);
    checkOutput("async_reset_corr_out", int'(bus2.corr_out), 0);
    checkOutput("async_reset_bit_valid", int'(bus2.bit_valid), 0);
    #1 rstn = 1'b1;
    send_frame(vecs[1], 1'b0);
    applyStimulus(8'sd0, 1'b0, 1'b0);
    wait_drain("drain_post_reset");

    // SF=3: index walks 0..5 and wraps; 12 chips give two decisions.
    for (int i = 0; i < 12; i++) s3[i] = 8'($urandom_range(0, 255));
    for (int f = 0; f < 2; f++) begin
      exp_t e;
      e.corr = 0;
      for (int k = 0; k < 3; k++) e.corr += int'(s3[6*f+3+k]) * int'(s3[6*f+k]);
      e.b = (e.corr > 0);
      q3.push_back(e);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("chip_index_sf3", int'(bus3.chip_index), i % 6);
      bus3.chip_in    = s3[i];
      bus3.chip_valid = 1'b1;
    end
    @(negedge clk);
    bus3.chip_valid = 1'b0;
    checkOutput("chip_index_sf3_wrap", int'(bus3.chip_index), 0);
    wait_drain("drain_sf3");
    checkOutput("pulses_sf3", pulses3, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
